// File: rtl/word_piso_unload.sv
// Parallel-in / serial-out word unloader.
//
// Captures DEPTH words of WIDTH bits in one cycle. It then presents them on
// dout_o one per enabled cycle, starting with word 0. valid_o, last_o and
// busy_o frame the stream for the next stage.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   ce_i        clock enable; when low every register holds and load_i is ignored
//   load_i      capture din_all_i (sampled only when ce_i is high)
//   din_all_i   packed input words, word k = din_all_i[k*WIDTH +: WIDTH]
//   dout_o      current word (head of the shift register)
//   valid_o     dout_o holds an unconsumed word
//   last_o      valid_o and dout_o is the final word of the load
//   busy_o      same as valid_o; a load is accepted only on the last word
//   count_o     words remaining, including the current one
//   ovr_o       sticky flag: a load was rejected while busy (reset clears it)
module word_piso_unload #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 3,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ce_i,
    input  logic                   load_i,
    input  logic [WIDTH*DEPTH-1:0] din_all_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   valid_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic [CntW-1:0]        count_o,
    output logic                   ovr_o
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e                 state_q, state_d;
    logic [WIDTH*DEPTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   ovr_q, ovr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            shreg_q <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (ce_i) begin
            unique case (state_q)
                StIdle: begin
                    if (load_i) begin
                        shreg_d = din_all_i;
                        count_d = CntFull;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (count_q > CntOne) begin
                        // Consume the head word; a load here is dropped and flagged.
                        shreg_d = shreg_q >> WIDTH;
                        count_d = count_q - CntOne;
                        if (load_i) begin
                            ovr_d = 1'b1;
                        end
                    end else if (load_i) begin
                        // The last word is consumed this cycle, so reload with no bubble.
                        shreg_d = din_all_i;
                        count_d = CntFull;
                    end else begin
                        shreg_d = '0;
                        count_d = '0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign dout_o  = shreg_q[WIDTH-1:0];
    assign valid_o = (state_q == StShift);
    assign busy_o  = valid_o;
    assign last_o  = valid_o && (count_q == CntOne);
    assign count_o = count_q;
    assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_word_piso_unload.sv
module tb_word_piso_unload;

    logic        clk_i = 1'b0;
    logic        rst_ni;

    // Default configuration: WIDTH=4, DEPTH=3
    logic        ce, load;
    logic [11:0] din;
    logic [3:0]  dout;
    logic        valid, last, busy, ovr;
    logic [1:0]  count;

    // Wide configuration: WIDTH=8, DEPTH=5
    logic        ce8, load8;
    logic [39:0] din8;
    logic [7:0]  dout8;
    logic        valid8, last8, busy8, ovr8;
    logic [2:0]  count8;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    word_piso_unload #(.WIDTH(4), .DEPTH(3)) u_dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ce_i      (ce),
        .load_i    (load),
        .din_all_i (din),
        .dout_o    (dout),
        .valid_o   (valid),
        .last_o    (last),
        .busy_o    (busy),
        .count_o   (count),
        .ovr_o     (ovr)
    );

    word_piso_unload #(.WIDTH(8), .DEPTH(5)) u_dut8 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ce_i      (ce8),
        .load_i    (load8),
        .din_all_i (din8),
        .dout_o    (dout8),
        .valid_o   (valid8),
        .last_o    (last8),
        .busy_o    (busy8),
        .count_o   (count8),
        .ovr_o     (ovr8)
    );

    typedef struct {
        logic        ce;
        logic        load;
        logic [11:0] din;
        logic [3:0]  dout;
        logic        valid;
        logic        last;
        logic [1:0]  count;
        logic        ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [3:0] e_dout,
                             input logic e_valid, input logic e_last,
                             input logic [1:0] e_count, input logic e_ovr);
        check({tag, ".dout"},  idx, 16'(dout),  16'(e_dout));
        check({tag, ".valid"}, idx, 16'(valid), 16'(e_valid));
        check({tag, ".busy"},  idx, 16'(busy),  16'(e_valid));
        check({tag, ".last"},  idx, 16'(last),  16'(e_last));
        check({tag, ".count"}, idx, 16'(count), 16'(e_count));
        check({tag, ".ovr"},   idx, 16'(ovr),   16'(e_ovr));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Each row: apply inputs, clock once, then compare the registered outputs.
        // T2 basic unload
        vecs.push_back('{1'b1, 1'b1, 12'h9A5, 4'h5, 1'b1, 1'b0, 2'd3, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'hA, 1'b1, 1'b0, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h9, 1'b1, 1'b1, 2'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0});
        // T3 enable gating; load pulses with ce=0 must not set ovr
        vecs.push_back('{1'b1, 1'b1, 12'h9A5, 4'h5, 1'b1, 1'b0, 2'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'h321, 4'h5, 1'b1, 1'b0, 2'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 12'h321, 4'h5, 1'b1, 1'b0, 2'd3, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'hA, 1'b1, 1'b0, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h9, 1'b1, 1'b1, 2'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0});
        // T4 back-to-back reload on the last word
        vecs.push_back('{1'b1, 1'b1, 12'h9A5, 4'h5, 1'b1, 1'b0, 2'd3, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'hA, 1'b1, 1'b0, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h9, 1'b1, 1'b1, 2'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 12'h321, 4'h1, 1'b1, 1'b0, 2'd3, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h2, 1'b1, 1'b0, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h3, 1'b1, 1'b1, 2'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0});
        // T5 overrun: load while count=2 is rejected, stream unaltered
        vecs.push_back('{1'b1, 1'b1, 12'h9A5, 4'h5, 1'b1, 1'b0, 2'd3, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'hA, 1'b1, 1'b0, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 12'h321, 4'h9, 1'b1, 1'b1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 2'd0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 2'd0, 1'b1});
        // Idle with ce=0: load ignored
        vecs.push_back('{1'b0, 1'b1, 12'h321, 4'h0, 1'b0, 1'b0, 2'd0, 1'b1});

        rst_ni = 1'b0;
        ce = 1'b0; load = 1'b0; din = '0;
        ce8 = 1'b0; load8 = 1'b0; din8 = '0;
        #12;
        check_all("reset", 0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        rst_ni = 1'b1;
        step();
        check_all("post_reset", 0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);

        foreach (vecs[i]) begin
            ce   = vecs[i].ce;
            load = vecs[i].load;
            din  = vecs[i].din;
            step();
            check_all("vec", i, vecs[i].dout, vecs[i].valid, vecs[i].last,
                      vecs[i].count, vecs[i].ovr);
        end

        // T1: asynchronous reset mid-stream with count=2 (ovr is set from T5)
        ce = 1'b1; load = 1'b1; din = 12'h9A5;
        step();
        load = 1'b0; din = '0;
        step();
        check_all("t1_pre", 0, 4'hA, 1'b1, 1'b0, 2'd2, 1'b1);
        ce = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_all("t1_async", 0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ce = 1'b1;
        step();
        check_all("t1_hold", 0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        check_all("t1_hold", 1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        load = 1'b1; din = 12'h321;
        step();
        load = 1'b0;
        check_all("t1_reload", 0, 4'h1, 1'b1, 1'b0, 2'd3, 1'b0);
        ce = 1'b0;

        // T6: WIDTH=8, DEPTH=5
        ce8 = 1'b1; load8 = 1'b1; din8 = 40'h4433221100;
        step();
        load8 = 1'b0; din8 = '0;
        for (int k = 0; k < 5; k++) begin
            check("t6.dout",  k, 16'(dout8),  16'(8'h11 * k));
            check("t6.count", k, 16'(count8), 16'(5 - k));
            check("t6.valid", k, 16'(valid8), 16'd1);
            check("t6.last",  k, 16'(last8),  16'(k == 4));
            step();
        end
        check("t6.idle_valid", 0, 16'(valid8), 16'd0);
        check("t6.idle_count", 0, 16'(count8), 16'd0);
        check("t6.idle_dout",  0, 16'(dout8),  16'd0);
        check("t6.ovr",        0, 16'(ovr8),   16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
